// File: rtl/uart_pkg.sv
// Shared UART definitions so uart_tx and uart_rx agree on the frame format.
package uart_pkg;

   localparam int unsigned DEF_CLOCKS_PER_PULSE = 4;
   localparam int unsigned DEF_BITS_PER_WORD    = 8;
   localparam int unsigned DEF_END_BITS         = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      END   = 2'd3
   } rx_state_t;

   // Total bits on the line for one frame: start + data + end bits.
   function automatic int unsigned packet_size(input int unsigned bits_per_word,
                                               input int unsigned end_bits);
      return bits_per_word + end_bits + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; both settle to RESET_VAL in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: assembles NUM_WORDS frames into one word on a valid/ready stream.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
   parameter int unsigned BITS_PER_WORD    = DEF_BITS_PER_WORD,
   parameter int unsigned W_OUT            = 16,
   parameter int unsigned END_BITS         = DEF_END_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   output logic [W_OUT-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             frame_err,
   output logic             overrun
);

   localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
   localparam int unsigned CLK_W     = $clog2(CLOCKS_PER_PULSE);
   localparam int unsigned MAX_BITS  = (BITS_PER_WORD > END_BITS) ? BITS_PER_WORD : END_BITS;
   localparam int unsigned BIT_W     = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
   localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned MID       = CLOCKS_PER_PULSE / 2 - 1;

   if (((W_OUT % BITS_PER_WORD) != 0) || (CLOCKS_PER_PULSE < 4)) begin : g_param_check
      $error("uart_rx: W_OUT must be a multiple of BITS_PER_WORD and CLOCKS_PER_PULSE >= 4");
   end

   rx_state_t                state;
   logic                     rx_s;
   logic [CLK_W-1:0]         c_clk;
   logic [BIT_W-1:0]         c_bit;
   logic [BITS_PER_WORD-1:0] shift;
   logic                     bad;
   logic [IDX_W-1:0]         idx;
   logic [W_OUT-1:0]         asm_buf;
   logic                     xfer_done;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // Frame FSM: start detection, mid-bit sampling, end-bit check and word assembly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         c_clk     <= '0;
         c_bit     <= '0;
         shift     <= '0;
         bad       <= 1'b0;
         idx       <= '0;
         asm_buf   <= '0;
         xfer_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         xfer_done <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  c_clk <= '0;
               end
            end
            START: begin
               if (c_clk == CLK_W'(MID)) begin
                  c_clk <= '0;
                  c_bit <= '0;
                  // A high line at the start-bit midpoint was only a glitch.
                  state <= rx_s ? IDLE : DATA;
               end else begin
                  c_clk <= c_clk + 1'b1;
               end
            end
            DATA: begin
               if (c_clk == CLK_W'(CLOCKS_PER_PULSE - 1)) begin
                  c_clk <= '0;
                  shift <= {rx_s, shift[BITS_PER_WORD-1:1]};
                  if (c_bit == BIT_W'(BITS_PER_WORD - 1)) begin
                     c_bit <= '0;
                     bad   <= 1'b0;
                     state <= END;
                  end else begin
                     c_bit <= c_bit + 1'b1;
                  end
               end else begin
                  c_clk <= c_clk + 1'b1;
               end
            end
            END: begin
               if (c_clk == CLK_W'(CLOCKS_PER_PULSE - 1)) begin
                  c_clk <= '0;
                  if (c_bit == BIT_W'(END_BITS - 1)) begin
                     c_bit <= '0;
                     bad   <= 1'b0;
                     state <= IDLE;
                     if (bad || !rx_s) begin
                        frame_err <= 1'b1;
                        idx       <= '0;
                     end else begin
                        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                           if (idx == IDX_W'(w)) begin
                              asm_buf[w*BITS_PER_WORD +: BITS_PER_WORD] <= shift;
                           end
                        end
                        if (idx == IDX_W'(NUM_WORDS - 1)) begin
                           idx       <= '0;
                           xfer_done <= 1'b1;
                        end else begin
                           idx <= idx + 1'b1;
                        end
                     end
                  end else begin
                     c_bit <= c_bit + 1'b1;
                     if (!rx_s) begin
                        bad <= 1'b1;
                     end
                  end
               end else begin
                  c_clk <= c_clk + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output stream register: load on completion unless the previous word is still stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data  <= '0;
         m_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (xfer_done) begin
            if (!m_valid || m_ready) begin
               m_data  <= asm_buf;
               m_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a behavioural serial transmitter.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int unsigned CPP       = 4;
   localparam int unsigned BPW       = 8;
   localparam int unsigned W_OUT     = 16;
   localparam int unsigned END_BITS  = 4;
   localparam int unsigned FRAME_LEN = packet_size(BPW, END_BITS);
   localparam int unsigned NUM_WORDS = W_OUT / BPW;
   // Line edge -> synchronized (2) -> noticed in idle (1) -> midpoint of last bit -> registered output (1).
   localparam int unsigned LAT       = 2 + 1 + CPP/2 + CPP*(FRAME_LEN-1) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             rx;
   logic [W_OUT-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             frame_err;
   logic             overrun;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int last_start = 0;

   int valid_rises = 0;
   int last_rise_cyc = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int last_ov_cyc = 0;
   logic [W_OUT-1:0] acc_q[$];
   logic [W_OUT-1:0] exp_q[$];
   logic prev_valid = 1'b0;
   logic prev_stall = 1'b0;
   logic [W_OUT-1:0] prev_data = '0;
   logic rand_ready_en = 1'b0;

   uart_rx #(
      .CLOCKS_PER_PULSE (CPP),
      .BITS_PER_WORD    (BPW),
      .W_OUT            (W_OUT),
      .END_BITS         (END_BITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (rand_ready_en) begin
         #1;
         m_ready = 1'($urandom_range(0, 1));
      end
   end

   // Observe the stream on the falling edge: handshakes, pulses and stall stability.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (m_valid && !prev_valid) begin
            valid_rises++;
            last_rise_cyc = cyc;
         end
         if (frame_err) fe_cnt++;
         if (overrun) begin
            ov_cnt++;
            last_ov_cyc = cyc;
         end
         if (prev_stall) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
               n_err++;
               $display("FAIL stall_hold: got valid=%b data=%h required valid=1 data=%h", m_valid, m_data, prev_data);
            end
         end
         if (m_valid && m_ready) acc_q.push_back(m_data);
         prev_stall = m_valid && !m_ready;
         prev_valid = m_valid;
         prev_data  = m_data;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPP) @(posedge clk);
      #1;
   endtask

   // bad_end selects one end bit to drive low (-1 for a clean frame).
   task automatic send_frame(input logic [BPW-1:0] d, input int bad_end);
      @(posedge clk);
      #1;
      last_start = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < int'(BPW); i++) drive_bit(d[i]);
      for (int i = 0; i < int'(END_BITS); i++) drive_bit(i == bad_end ? 1'b0 : 1'b1);
   endtask

   task automatic send_word(input logic [W_OUT-1:0] w);
      for (int k = 0; k < int'(NUM_WORDS); k++) send_frame(w[k*BPW +: BPW], -1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int n, input string name);
      int budget;
      budget = 2000;
      while (acc_q.size() < n && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #1;
      if (acc_q.size() < n) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got %0d accepted words required %0d", name, acc_q.size(), n);
      end
   endtask

   task automatic check_pop(input logic [W_OUT-1:0] expv, input string name);
      logic [W_OUT-1:0] got;
      n_cmp++;
      if (acc_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: got no word required %h", name, expv);
      end else begin
         got = acc_q.pop_front();
         if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, expv);
         end
      end
   endtask

   task automatic check_int(input int got, input int expv, input string name);
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, got, expv);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx = 1'b1;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (m_data !== '0 || m_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got data=%h valid=%b fe=%b ov=%b required all 0", m_data, m_valid, frame_err, overrun);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_cycles(5);
   endtask

   task automatic test_basic();
      int r0, f0, o0;
      r0 = valid_rises; f0 = fe_cnt; o0 = ov_cnt;
      m_ready = 1'b1;
      send_frame(8'hA5, -1);
      send_frame(8'h3C, -1);
      wait_acc(1, "basic");
      wait_cycles(10);
      check_pop(16'h3CA5, "basic_data");
      check_int(valid_rises - r0, 1, "basic_valid_pulses");
      check_int(last_rise_cyc, last_start + int'(LAT), "basic_valid_latency");
      check_int(fe_cnt - f0, 0, "basic_frame_err");
      check_int(ov_cnt - o0, 0, "basic_overrun");
   endtask

   task automatic test_overrun();
      int o0;
      o0 = ov_cnt;
      m_ready = 1'b0;
      send_frame(8'h12, -1);
      send_frame(8'h34, -1);
      wait_cycles(10);
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 16'h3412) begin
         n_err++;
         $display("FAIL ovr_first: got valid=%b data=%h required valid=1 data=3412", m_valid, m_data);
      end
      send_frame(8'h56, -1);
      send_frame(8'h78, -1);
      wait_cycles(10);
      check_int(ov_cnt - o0, 1, "ovr_pulses");
      check_int(last_ov_cyc, last_start + int'(LAT), "ovr_latency");
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 16'h3412) begin
         n_err++;
         $display("FAIL ovr_hold: got valid=%b data=%h required valid=1 data=3412", m_valid, m_data);
      end
      m_ready = 1'b1;
      wait_cycles(2);
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_release: got valid=%b required 0", m_valid);
      end
      check_pop(16'h3412, "ovr_accepted");
      check_int(acc_q.size(), 0, "ovr_no_extra");
      send_frame(8'h9A, -1);
      send_frame(8'hBC, -1);
      wait_acc(1, "ovr_next");
      check_pop(16'hBC9A, "ovr_next_data");
   endtask

   task automatic test_glitch();
      int r0, f0;
      r0 = valid_rises; f0 = fe_cnt;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      rx = 1'b0;
      @(posedge clk);
      #1;
      rx = 1'b1;
      wait_cycles(40);
      check_int(valid_rises - r0, 0, "glitch_no_valid");
      check_int(fe_cnt - f0, 0, "glitch_no_err");
      send_frame(8'h01, -1);
      send_frame(8'h02, -1);
      wait_acc(1, "glitch");
      check_pop(16'h0201, "glitch_next_data");
   endtask

   task automatic test_frame_err();
      int r0, f0;
      r0 = valid_rises; f0 = fe_cnt;
      m_ready = 1'b1;
      send_frame(8'h77, -1);
      send_frame(8'hFF, 2);
      wait_cycles(10);
      check_int(fe_cnt - f0, 1, "ferr_pulses");
      check_int(valid_rises - r0, 0, "ferr_no_valid");
      send_frame(8'h11, -1);
      send_frame(8'h22, -1);
      wait_acc(1, "ferr_next");
      check_pop(16'h2211, "ferr_next_data");
      check_int(fe_cnt - f0, 1, "ferr_no_more");
   endtask

   task automatic test_reset_mid();
      logic [BPW-1:0] d;
      int f0;
      d = 8'hE7;
      m_ready = 1'b1;
      send_frame(8'h44, -1);
      @(posedge clk);
      #1;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      rx = d[4];
      repeat (CPP/2) @(posedge clk);
      #1;
      f0 = fe_cnt;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (m_data !== '0 || m_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got data=%h valid=%b fe=%b ov=%b required all 0", m_data, m_valid, frame_err, overrun);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      rx = 1'b1;
      wait_cycles(10);
      check_int(fe_cnt - f0, 0, "rst_mid_no_err");
      send_frame(8'hC3, -1);
      send_frame(8'h5A, -1);
      wait_acc(1, "rst_mid");
      check_pop(16'h5AC3, "rst_mid_data");
   endtask

   task automatic test_loopback();
      logic [W_OUT-1:0] w;
      int o0, f0;
      acc_q.delete();
      exp_q.delete();
      rand_ready_en = 1'b1;
      for (int n = 0; n < 10; n++) begin
         w = W_OUT'($urandom);
         exp_q.push_back(w);
         send_word(w);
         wait_cycles(int'($urandom_range(0, 5)));
      end
      wait_acc(10, "loop_rand");
      rand_ready_en = 1'b0;
      wait_cycles(2);
      m_ready = 1'b1;
      o0 = ov_cnt; f0 = fe_cnt;
      for (int n = 0; n < 5; n++) begin
         w = W_OUT'($urandom);
         exp_q.push_back(w);
         send_word(w);
      end
      wait_acc(15, "loop_ready");
      wait_cycles(5);
      check_int(acc_q.size(), exp_q.size(), "loop_count");
      while (exp_q.size() > 0) check_pop(exp_q.pop_front(), "loop_word");
      check_int(ov_cnt - o0, 0, "loop_overrun");
      check_int(fe_cnt - f0, 0, "loop_frame_err");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
